// File: rtl/fib_timer_bank.sv
// Three independent one-shot countdown timers that pace the Fibonacci LED sequencer.
// A start request loads TN_TICKS-1; expiry returns a single-cycle registered interrupt pulse.
module fib_timer_bank #(
    parameter int COUNT_WIDTH = 24,
    parameter int T0_TICKS    = 12000000,
    parameter int T1_TICKS    = 6000000,
    parameter int T2_TICKS    = 3000000
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       t0_start_in,
    input  logic       t1_start_in,
    input  logic       t2_start_in,
    output logic       t0_int_out,
    output logic       t1_int_out,
    output logic       t2_int_out,
    output logic [2:0] busy_out
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam longint MAX_TICKS = longint'(1) << COUNT_WIDTH;

    logic [2:0] start_vec;
    logic [2:0] int_vec;
    logic [2:0] busy_vec;

    assign start_vec = {t2_start_in, t1_start_in, t0_start_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            localparam int TICKS = (gi == 0) ? T0_TICKS :
                                   (gi == 1) ? T1_TICKS : T2_TICKS;

            if (TICKS < 1 || longint'(TICKS) > MAX_TICKS) begin : g_bad_ticks
                $error("fib_timer_bank: channel tick count out of range");
            end

            localparam logic [COUNT_WIDTH-1:0] LOAD_VALUE = COUNT_WIDTH'(TICKS - 1);

            state_t                 state_reg, state_next;
            logic [COUNT_WIDTH-1:0] count_reg, count_next;
            logic                   int_reg, int_next;

            // Reset wins over everything, including an expiry on the same edge.
            always_ff @(posedge clock_in) begin
                if (!reset_in) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    int_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    int_reg   <= int_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE:    if (start_vec[gi])          state_next = RUN;
                    RUN:     if (count_reg == '0)        state_next = IDLE;
                    default:                             state_next = IDLE;
                endcase
            end

            // Start is ignored while running: no retrigger, no extension.
            always_comb begin
                count_next = count_reg;
                int_next   = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (start_vec[gi]) count_next = LOAD_VALUE;
                    end
                    RUN: begin
                        if (count_reg != '0) count_next = count_reg - COUNT_WIDTH'(1);
                        else                 int_next   = 1'b1;
                    end
                    default: count_next = '0;
                endcase
            end

            assign int_vec[gi]  = int_reg;
            assign busy_vec[gi] = (state_reg == RUN);
        end
    endgenerate

    assign t0_int_out = int_vec[0];
    assign t1_int_out = int_vec[1];
    assign t2_int_out = int_vec[2];
    assign busy_out   = busy_vec;

endmodule

// File: tb/tb_fib_timer_bank.sv
// Directed bench for fib_timer_bank with T0=5, T1=3, T2=1, COUNT_WIDTH=4.
// Observed word per check is {busy_out[2:0], t2_int, t1_int, t0_int}.
module tb_fib_timer_bank;

    logic       clk;
    logic       reset_in;
    logic       t0_start, t1_start, t2_start;
    logic       t0_int, t1_int, t2_int;
    logic [2:0] busy;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    fib_timer_bank #(
        .COUNT_WIDTH(4),
        .T0_TICKS   (5),
        .T1_TICKS   (3),
        .T2_TICKS   (1)
    ) dut (
        .clock_in   (clk),
        .reset_in   (reset_in),
        .t0_start_in(t0_start),
        .t1_start_in(t1_start),
        .t2_start_in(t2_start),
        .t0_int_out (t0_int),
        .t1_int_out (t1_int),
        .t2_int_out (t2_int),
        .busy_out   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {busy, t2_int, t1_int, t0_int};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-14s busy/ints=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s value=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        reset_in = 1'b0;
        t0_start = 1'b1; t1_start = 1'b1; t2_start = 1'b1;

        // Reset held with all starts high
        for (int i = 0; i < 3; i++) begin
            tick(); chk("reset_hold", 6'b000_000);
        end
        t0_start = 1'b0; t1_start = 1'b0; t2_start = 1'b0;
        reset_in = 1'b1;
        tick(); chk("post_reset", 6'b000_000);

        // Single shot ch0: busy 5 cycles, int after E5
        t0_start = 1'b1;
        tick(); chk("ch0_E0", 6'b001_000);
        t0_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); chk("ch0_run", 6'b001_000);
        end
        tick(); chk("ch0_E5_int", 6'b000_001);
        tick(); chk("ch0_E6_idle", 6'b000_000);

        // Periodic ch2 with TICKS=1: period 2, five pulses in ten edges
        pulses = 0;
        t2_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (t2_int) pulses++;
            chk("ch2_periodic", (i % 2 == 0) ? 6'b100_000 : 6'b000_100);
        end
        t2_start = 1'b0;
        tick(); chk("ch2_stop", 6'b000_000);
        chk_int("ch2_pulses", pulses, 5);

        // Retrigger ignored on ch1
        t1_start = 1'b1;
        tick(); chk("ch1_E0", 6'b010_000);
        tick(); chk("ch1_E1_retrig", 6'b010_000);
        t1_start = 1'b0;
        tick(); chk("ch1_E2", 6'b010_000);
        tick(); chk("ch1_E3_int", 6'b000_010);
        tick(); chk("ch1_E4", 6'b000_000);
        tick(); chk("ch1_E5_noext", 6'b000_000);

        // Concurrent start of all channels
        t0_start = 1'b1; t1_start = 1'b1; t2_start = 1'b1;
        tick(); chk("all_E0", 6'b111_000);
        t0_start = 1'b0; t1_start = 1'b0; t2_start = 1'b0;
        tick(); chk("all_E1", 6'b011_100);
        tick(); chk("all_E2", 6'b011_000);
        tick(); chk("all_E3", 6'b001_010);
        tick(); chk("all_E4", 6'b001_000);
        tick(); chk("all_E5", 6'b000_001);
        tick(); chk("all_E6", 6'b000_000);

        // Reset mid-count on ch0 aborts without a pulse
        t0_start = 1'b1;
        tick(); chk("abort_E0", 6'b001_000);
        t0_start = 1'b0;
        tick(); chk("abort_E1", 6'b001_000);
        tick(); chk("abort_E2", 6'b001_000);
        reset_in = 1'b0;
        tick(); chk("abort_E3_rst", 6'b000_000);
        reset_in = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            tick(); chk("abort_quiet", 6'b000_000);
        end

        // Fresh start after reset
        t0_start = 1'b1;
        tick(); chk("fresh_E0", 6'b001_000);
        t0_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); chk("fresh_run", 6'b001_000);
        end
        tick(); chk("fresh_E5_int", 6'b000_001);
        tick(); chk("fresh_E6", 6'b000_000);

        // Reset on the expiry edge suppresses the pulse (ch2, TICKS=1)
        t2_start = 1'b1;
        tick(); chk("exprst_E0", 6'b100_000);
        t2_start = 1'b0;
        reset_in = 1'b0;
        tick(); chk("exprst_E1", 6'b000_000);
        reset_in = 1'b1;
        tick(); chk("exprst_E2", 6'b000_000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
